// File: rtl/z80_inta_responder_pkg.sv
// Shared types and constants for the Z80 mode-0 interrupt-acknowledge responder.
package z80_inta_responder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ACK,
    HOLD,
    REARM
  } state_e;

  localparam logic [7:0] RST_BASE     = 8'hC7;
  localparam logic [7:0] SPURIOUS_VEC = 8'h38;

  // RST vectors are multiples of 8, so bits [5:3] pick the source.
  function automatic logic [2:0] vec_index(input logic [7:0] vec);
    return vec[5:3];
  endfunction

endpackage

// File: rtl/z80_inta_responder_bus_sync.sv
// Multi-stage synchronizer for asynchronous Z80 bus strobes.
module z80_inta_responder_bus_sync
  import z80_inta_responder_pkg::*;
#(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/z80_inta_responder.sv
// Z80 mode-0 INTA responder: drives /INT, answers INTA with an RST opcode and a one-hot ack.
// Optional spurious-INTA counter is built when SPURIOUS_CNT_EN is defined.
module z80_inta_responder
  import z80_inta_responder_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int REARM_CYCLES = 8
) (
  input  logic       pll0_250MHz,
  input  logic       reset,
  input  logic [7:0] int_vec,
  input  logic       ints_gs,
  input  logic       cpu_m1_n,
  input  logic       cpu_iorq_n,
  output logic       cpu_int_n,
  output logic [7:0] dout,
  output logic       dout_oe,
  output logic [7:0] ack,
  output logic       busy
`ifdef SPURIOUS_CNT_EN
  ,
  output logic [7:0] spur_cnt
`endif
);

  logic   m1_s, iorq_s, inta_s;
  state_e state_q;
  logic   int_n_q, oe_q;
  logic [7:0] dout_q, ack_q, rearm_q;
`ifdef SPURIOUS_CNT_EN
  logic [7:0] spur_q;
`endif

  z80_inta_responder_bus_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_m1 (
    .clk_i (pll0_250MHz),
    .rst_i (reset),
    .d_i   (cpu_m1_n),
    .q_o   (m1_s)
  );

  z80_inta_responder_bus_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_iorq (
    .clk_i (pll0_250MHz),
    .rst_i (reset),
    .d_i   (cpu_iorq_n),
    .q_o   (iorq_s)
  );

  assign inta_s = ~m1_s & ~iorq_s;

  always_ff @(posedge pll0_250MHz) begin
    if (reset) begin
      state_q <= IDLE;
      int_n_q <= 1'b1;
      dout_q  <= 8'h00;
      oe_q    <= 1'b0;
      ack_q   <= 8'h00;
      rearm_q <= 8'h00;
`ifdef SPURIOUS_CNT_EN
      spur_q  <= 8'h00;
`endif
    end else begin
      ack_q <= 8'h00;
      case (state_q)
        IDLE, REARM: begin
          if (inta_s) begin
            // Nobody of ours asked: answer RST 38h and acknowledge no source.
            state_q <= ACK;
            dout_q  <= RST_BASE | SPURIOUS_VEC;
            oe_q    <= 1'b1;
            int_n_q <= 1'b1;
            rearm_q <= 8'h00;
`ifdef SPURIOUS_CNT_EN
            if (spur_q != 8'hFF) spur_q <= spur_q + 8'd1;
`endif
          end else if (state_q == IDLE) begin
            if (!ints_gs) begin
              state_q <= REQ;
              int_n_q <= 1'b0;
            end
          end else if (rearm_q <= 8'd1) begin
            state_q <= IDLE;
            rearm_q <= 8'h00;
          end else begin
            rearm_q <= rearm_q - 8'd1;
          end
        end
        REQ: begin
          if (inta_s) begin
            state_q <= ACK;
            dout_q  <= RST_BASE | (int_vec & SPURIOUS_VEC);
            oe_q    <= 1'b1;
            int_n_q <= 1'b1;
            ack_q   <= 8'h01 << vec_index(int_vec);
          end else if (ints_gs) begin
            state_q <= IDLE;
            int_n_q <= 1'b1;
          end
        end
        ACK: begin
          state_q <= HOLD;
        end
        HOLD: begin
          if (iorq_s) begin
            state_q <= REARM;
            oe_q    <= 1'b0;
            dout_q  <= 8'h00;
            rearm_q <= 8'(REARM_CYCLES);
          end
        end
        default: begin
          state_q <= IDLE;
          int_n_q <= 1'b1;
          oe_q    <= 1'b0;
          dout_q  <= 8'h00;
        end
      endcase
    end
  end

  assign cpu_int_n = int_n_q;
  assign dout      = dout_q;
  assign dout_oe   = oe_q;
  assign ack       = ack_q;
  assign busy      = (state_q != IDLE);
`ifdef SPURIOUS_CNT_EN
  assign spur_cnt  = spur_q;
`endif

endmodule
